// File: rtl/led_play_arbiter.sv
// rtl/led_play_arbiter.sv - round-robin arbiter sharing one LED pattern sequencer between requesters
// Optional watchdog: define LED_ARB_TIMEOUT_EN to enable the WAIT-state timeout.
module led_play_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TW             = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               led_end,
  output logic               led_on,
  output logic               busy,
  output logic [IDW-1:0]     grant_id,
  output logic [NUM_REQ-1:0] pending,
  output logic [NUM_REQ-1:0] ack,
  output logic               timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [NUM_REQ-1:0] r_req_prev;
  logic [NUM_REQ-1:0] r_pending;
  logic [IDW-1:0]     r_grant_id;
  logic [IDW-1:0]     r_last;

  logic [NUM_REQ-1:0] w_rise;
  logic [NUM_REQ-1:0] w_clr;
  logic [NUM_REQ-1:0] w_ack_mask;
  logic [IDW-1:0]     w_sel;
  logic               w_any;
  logic               w_grant;
  logic               w_to_hit;
  logic               w_ack_en;

  assign w_rise     = req & ~r_req_prev;
  assign w_any      = |r_pending;
  assign w_grant    = (r_state == S_IDLE) && w_any;
  assign w_clr      = w_grant ? (NUM_REQ'(1) << w_sel) : '0;
  assign w_ack_mask = NUM_REQ'(1) << r_grant_id;

  assign grant_id   = r_grant_id;
  assign pending    = r_pending;

  // Round-robin pick: scan from farthest to nearest after r_last so the nearest pending index wins
  always_comb begin
    int                 idx;
    logic [NUM_REQ-1:0] shifted;
    w_sel   = r_last;
    idx     = 0;
    shifted = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = int'(r_last) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      shifted = r_pending >> idx;
      if (shifted[0]) begin
        w_sel = IDW'(idx);
      end
    end
  end

`ifdef LED_ARB_TIMEOUT_EN
  logic [TW-1:0] r_wd;
  logic          r_to_taken;

  assign w_to_hit = (r_wd == TW'(TIMEOUT_CYCLES - 1));
  assign w_ack_en = ~r_to_taken;

  // Watchdog: cleared while entering WAIT, counts each WAIT cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd <= '0;
    end else if (r_state == S_START) begin
      r_wd <= '0;
    end else if (r_state == S_WAIT) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  // Remember that DONE was reached through the watchdog so its ack is suppressed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_taken <= 1'b0;
    end else begin
      r_to_taken <= timeout;
    end
  end
`else
  logic [TW-1:0] w_unused_limit;

  assign w_unused_limit = TW'(TIMEOUT_CYCLES - 1);
  assign w_to_hit       = 1'b0;
  assign w_ack_en       = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Edge capture, pending flags (set wins over clear), grant index and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_prev <= '0;
      r_pending  <= '0;
      r_grant_id <= IDW'(NUM_REQ - 1);
      r_last     <= IDW'(NUM_REQ - 1);
    end else begin
      r_req_prev <= req;
      r_pending  <= (r_pending & ~w_clr) | w_rise;
      if (w_grant) begin
        r_grant_id <= w_sel;
        r_last     <= w_sel;
      end
    end
  end

  // Next state and outputs decoded from the state register
  always_comb begin
    w_next  = r_state;
    led_on  = 1'b0;
    busy    = 1'b0;
    ack     = '0;
    timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = S_START;
        end
      end
      S_START: begin
        led_on = 1'b1;
        busy   = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (led_end) begin
          w_next = S_DONE;
        end else if (w_to_hit) begin
          timeout = 1'b1;
          w_next  = S_DONE;
        end
      end
      S_DONE: begin
        if (w_ack_en) begin
          ack = w_ack_mask;
        end
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_led_play_arbiter.sv
// tb/tb_led_play_arbiter.sv - self-checking bench for led_play_arbiter with a transaction-level reference model
module tb_led_play_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       led_end;
  logic       led_on;
  logic       busy;
  logic [1:0] grant_id;
  logic [3:0] pending;
  logic [3:0] ack;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;
  int tnow = 0;
  int prev_on = -100;

  logic [3:0] m_pend;
  int         m_last;

  led_play_arbiter #(
    .NUM_REQ(4),
    .IDW(2),
    .TIMEOUT_CYCLES(16),
    .TW(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .led_end(led_end),
    .led_on(led_on),
    .busy(busy),
    .grant_id(grant_id),
    .pending(pending),
    .ack(ack),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tnow++;
  endtask

  // Next requester after 'last' in circular order that has a pending play
  function automatic int pick(input logic [3:0] p, input int last);
    int i;
    for (int k = 1; k <= 4; k++) begin
      i = (last + k) % 4;
      if (((p >> i) & 4'd1) != 4'd0) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset   = 1'b1;
    req     = 4'b0;
    led_end = 1'b0;
    tick();
    tick();
    reset   = 1'b0;
    m_pend  = 4'b0;
    m_last  = 3;
    prev_on = -100;
  endtask

  // One-cycle request pulse: rising edge on every set bit of r
  task automatic pulse(input logic [3:0] r);
    req = r;
    tick();
    req = 4'b0;
    m_pend = m_pend | r;
  endtask

  task automatic wait_on(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (led_on === 1'b1) ok = 1'b1;
    end
  endtask

  // One complete play; want<0 lets the model choose; 'during' is pulsed in the first WAIT cycle
  task automatic serve(input int want, input int dly, input logic [3:0] during);
    bit ok;
    int exp_id;
    exp_id = (want < 0) ? pick(m_pend, m_last) : want;
    wait_on(ok);
    chk("led_on_seen", {31'b0, ok}, 32'd1);
    chk("grant_id", {30'b0, grant_id}, exp_id);
    chk("busy_start", {31'b0, busy}, 32'd1);
    chk("led_on_spacing", {31'b0, (tnow - prev_on) >= 4}, 32'd1);
    prev_on = tnow;
    m_pend[exp_id] = 1'b0;
    m_last = exp_id;
    chk("pending_after_grant", {28'b0, pending}, {28'b0, m_pend});
    tick();
    chk("led_on_one_cycle", {31'b0, led_on}, 32'd0);
    chk("busy_wait", {31'b0, busy}, 32'd1);
    if (during != 4'b0) pulse(during);
    repeat (dly) tick();
    chk("pending_in_wait", {28'b0, pending}, {28'b0, m_pend});
    led_end = 1'b1;
    tick();
    led_end = 1'b0;
    chk("ack", {28'b0, ack}, {28'b0, 4'b1 << exp_id});
    chk("busy_done", {31'b0, busy}, 32'd0);
    chk("timeout_done", {31'b0, timeout}, 32'd0);
    tick();
    chk("ack_one_cycle", {28'b0, ack}, 32'd0);
  endtask

  initial begin
    bit ok;
    int cnt;
    logic [3:0] r;

    // Reset values
    reset = 1'b1; req = 4'b0; led_end = 1'b0;
    tick();
    chk("rst_led_on", {31'b0, led_on}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_grant_id", {30'b0, grant_id}, 32'd3);
    chk("rst_pending", {28'b0, pending}, 32'd0);
    chk("rst_ack", {28'b0, ack}, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    do_reset();

    // Single request latency
    repeat (3) tick();
    req = 4'b0100;
    tick();
    chk("single_pending", {28'b0, pending}, 32'h4);
    chk("single_led_on_early", {31'b0, led_on}, 32'd0);
    req = 4'b0;
    tick();
    chk("single_led_on", {31'b0, led_on}, 32'd1);
    chk("single_grant", {30'b0, grant_id}, 32'd2);
    chk("single_pending_clr", {28'b0, pending}, 32'd0);
    tick();
    chk("single_led_on_off", {31'b0, led_on}, 32'd0);
    chk("single_busy_wait", {31'b0, busy}, 32'd1);
    repeat (26) tick();
    led_end = 1'b1;
    tick();
    led_end = 1'b0;
    chk("single_ack", {28'b0, ack}, 32'h4);
    chk("single_busy_done", {31'b0, busy}, 32'd0);
    tick();
    chk("single_ack_off", {28'b0, ack}, 32'd0);

    // Simultaneous requests after reset are served 0,1,2,3
    do_reset();
    pulse(4'b1111);
    chk("sim_pending", {28'b0, pending}, 32'hF);
    for (int k = 0; k < 4; k++) serve(k, 20, 4'b0);

    // Round-robin from last=1 and re-request during own WAIT
    do_reset();
    pulse(4'b0010);
    serve(1, 2, 4'b0101);
    serve(2, 3, 4'b0100);
    serve(0, 2, 4'b0);
    serve(2, 2, 4'b0);

    // Set/clear collision on requester 3, then absorption of repeated edges on 1
    do_reset();
    pulse(4'b0001);
    serve(0, 0, 4'b1000);
    req = 4'b1000;
    tick();
    req = 4'b0;
    chk("coll_led_on", {31'b0, led_on}, 32'd1);
    chk("coll_grant", {30'b0, grant_id}, 32'd3);
    chk("coll_pending_kept", {28'b0, pending}, 32'h8);
    prev_on = tnow;
    m_last = 3;
    m_pend = 4'b1000;
    tick();
    pulse(4'b0010);
    tick();
    pulse(4'b0010);
    tick();
    pulse(4'b0010);
    chk("absorb_pending", {28'b0, pending}, 32'hA);
    led_end = 1'b1;
    tick();
    led_end = 1'b0;
    chk("coll_ack", {28'b0, ack}, 32'h8);
    tick();
    serve(1, 2, 4'b0);
    serve(3, 2, 4'b0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (led_on !== 1'b0) cnt++;
    end
    chk("absorb_no_extra_play", cnt, 32'd0);
    chk("absorb_pending_empty", {28'b0, pending}, 32'd0);

    // Reset in WAIT with pending 1010, late led_end ignored
    do_reset();
    pulse(4'b0001);
    wait_on(ok);
    chk("rmid_led_on_seen", {31'b0, ok}, 32'd1);
    tick();
    pulse(4'b1010);
    chk("rmid_pending", {28'b0, pending}, 32'hA);
    chk("rmid_busy", {31'b0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rmid_led_on", {31'b0, led_on}, 32'd0);
    chk("rmid_busy_rst", {31'b0, busy}, 32'd0);
    chk("rmid_grant_id", {30'b0, grant_id}, 32'd3);
    chk("rmid_pending_rst", {28'b0, pending}, 32'd0);
    chk("rmid_ack", {28'b0, ack}, 32'd0);
    tick();
    reset = 1'b0;
    led_end = 1'b1;
    tick();
    led_end = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (ack !== 4'b0 || led_on !== 1'b0 || busy !== 1'b0) cnt++;
      tick();
    end
    chk("rmid_late_led_end_ignored", cnt, 32'd0);
    m_pend = 4'b0;
    m_last = 3;

    // Randomized traffic against the reference model
    for (int rnd = 0; rnd < 20; rnd++) begin
      r = 4'($urandom_range(1, 15));
      pulse(r);
      chk("rand_pending", {28'b0, pending}, {28'b0, m_pend});
      for (int j = 0; j < 24 && m_pend != 4'b0; j++) begin
        serve(-1, $urandom_range(0, 6),
              ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0);
      end
      chk("rand_drained", {28'b0, pending}, {28'b0, m_pend});
    end

`ifdef LED_ARB_TIMEOUT_EN
    // Watchdog: timeout on the 16th WAIT cycle, then coincident led_end wins
    do_reset();
    pulse(4'b0011);
    wait_on(ok);
    chk("to_grant0", {30'b0, grant_id}, 32'd0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("to_early", {31'b0, timeout}, 32'd0);
    end
    tick();
    chk("to_pulse", {31'b0, timeout}, 32'd1);
    tick();
    chk("to_no_ack", {28'b0, ack}, 32'd0);
    chk("to_pulse_off", {31'b0, timeout}, 32'd0);
    wait_on(ok);
    chk("to_grant1", {30'b0, grant_id}, 32'd1);
    repeat (16) tick();
    led_end = 1'b1;
    #1;
    chk("to_led_end_wins", {31'b0, timeout}, 32'd0);
    tick();
    led_end = 1'b0;
    chk("to_coincident_ack", {28'b0, ack}, 32'h2);
`else
    chk("timeout_tied_low", {31'b0, timeout}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
